siw_memory_arbiter: RTL and testbench

- Two-requester round-robin arbiter for one port of a siw_memory_bram_* dual-port block RAM wrapper (one instance per RAM port).
- Sequences the port's configurable delayed-write strobe (mem_conf) and its 2-cycle registered read path.
- Returns read data tagged to the requester that issued the read.
- Sits between two datapath clients (e.g. loader and processing unit) and the RAM port.

---
 rtl/siw_memory_arbiter.sv | 175 +++++++++++++++++
 tb/tb_siw_memory_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/siw_memory_arbiter.sv
// Two-requester round-robin arbiter for one port of a siw_memory_bram_* RAM.
// Grants are issued combinationally in IDLE; a delayed write freezes the RAM
// bus in WR_HOLD until the RAM's delayed strobe has fired. Read results are
// tagged through a two-stage pipe matching the RAM's registered read path.
module siw_memory_arbiter #(
    parameter int unsigned AW       = 10,
    parameter int unsigned DW       = 32,
    parameter int unsigned WR_DELAY = 0
) (
    input  logic          siw_memory_arbiter_clk,
    input  logic          siw_memory_arbiter_reset_n,
    input  logic          siw_memory_arbiter_init,
    input  logic          siw_memory_arbiter_req_0,
    input  logic          siw_memory_arbiter_req_1,
    input  logic          siw_memory_arbiter_we_0,
    input  logic          siw_memory_arbiter_we_1,
    input  logic [AW-1:0] siw_memory_arbiter_addr_0,
    input  logic [AW-1:0] siw_memory_arbiter_addr_1,
    input  logic [DW-1:0] siw_memory_arbiter_wdata_0,
    input  logic [DW-1:0] siw_memory_arbiter_wdata_1,
    output logic          siw_memory_arbiter_gnt_0,
    output logic          siw_memory_arbiter_gnt_1,
    output logic          siw_memory_arbiter_rvalid_0,
    output logic          siw_memory_arbiter_rvalid_1,
    output logic [DW-1:0] siw_memory_arbiter_rdata,
    output logic          siw_memory_arbiter_busy,
    output logic          siw_memory_arbiter_mem_enable,
    output logic          siw_memory_arbiter_mem_write_en,
    output logic [AW-1:0] siw_memory_arbiter_mem_address,
    output logic [DW-1:0] siw_memory_arbiter_mem_input_data,
    output logic [1:0]    siw_memory_arbiter_mem_conf,
    output logic          siw_memory_arbiter_mem_init,
    input  logic [DW-1:0] siw_memory_arbiter_mem_output_data
);

    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] DELAY = CNT_W'(WR_DELAY);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_WR_HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [AW-1:0]    hold_addr_q, hold_addr_d;
    logic [DW-1:0]    hold_data_q, hold_data_d;
    logic             tag1_v_q, tag1_v_d;
    logic             tag1_id_q, tag1_id_d;
    logic             rvalid_0_q, rvalid_1_q;

    logic             sel;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;
    logic             gnt_0_c, gnt_1_c;
    logic             en_c, we_c;
    logic [AW-1:0]    addr_c;
    logic [DW-1:0]    data_c;

    // Winner select: alternate on conflict, otherwise whoever is requesting.
    always_comb begin
        sel = 1'b0;
        if (siw_memory_arbiter_req_0 && siw_memory_arbiter_req_1) begin
            sel = ~last_q;
        end else begin
            sel = siw_memory_arbiter_req_1;
        end
        sel_we    = sel ? siw_memory_arbiter_we_1    : siw_memory_arbiter_we_0;
        sel_addr  = sel ? siw_memory_arbiter_addr_1  : siw_memory_arbiter_addr_0;
        sel_wdata = sel ? siw_memory_arbiter_wdata_1 : siw_memory_arbiter_wdata_0;
    end

    // Next state, grant and RAM bus drive.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        tag1_v_d    = 1'b0;
        tag1_id_d   = 1'b0;
        gnt_0_c     = 1'b0;
        gnt_1_c     = 1'b0;
        en_c        = 1'b0;
        we_c        = 1'b0;
        addr_c      = '0;
        data_c      = '0;

        if (siw_memory_arbiter_init) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            last_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (siw_memory_arbiter_req_0 || siw_memory_arbiter_req_1) begin
                        gnt_0_c = ~sel;
                        gnt_1_c = sel;
                        last_d  = sel;
                        en_c    = 1'b1;
                        we_c    = sel_we;
                        addr_c  = sel_addr;
                        if (sel_we) begin
                            data_c = sel_wdata;
                            if (DELAY != '0) begin
                                state_d     = ST_WR_HOLD;
                                cnt_d       = DELAY;
                                hold_addr_d = sel_addr;
                                hold_data_d = sel_wdata;
                            end
                        end else begin
                            tag1_v_d  = 1'b1;
                            tag1_id_d = sel;
                        end
                    end
                end
                ST_WR_HOLD: begin
                    en_c   = 1'b1;
                    addr_c = hold_addr_q;
                    data_c = hold_data_q;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, pointer, hold registers and read tag pipe.
    always_ff @(posedge siw_memory_arbiter_clk or negedge siw_memory_arbiter_reset_n) begin
        if (!siw_memory_arbiter_reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            tag1_v_q    <= 1'b0;
            tag1_id_q   <= 1'b0;
            rvalid_0_q  <= 1'b0;
            rvalid_1_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            tag1_v_q    <= tag1_v_d;
            tag1_id_q   <= tag1_id_d;
            rvalid_0_q  <= ~siw_memory_arbiter_init & tag1_v_q & ~tag1_id_q;
            rvalid_1_q  <= ~siw_memory_arbiter_init & tag1_v_q & tag1_id_q;
        end
    end

    // Grant and bus outputs are held quiet while reset is asserted.
    always_comb begin
        siw_memory_arbiter_gnt_0          = siw_memory_arbiter_reset_n & gnt_0_c;
        siw_memory_arbiter_gnt_1          = siw_memory_arbiter_reset_n & gnt_1_c;
        siw_memory_arbiter_mem_enable     = siw_memory_arbiter_reset_n & en_c;
        siw_memory_arbiter_mem_write_en   = siw_memory_arbiter_reset_n & we_c;
        siw_memory_arbiter_mem_address    = siw_memory_arbiter_reset_n ? addr_c : '0;
        siw_memory_arbiter_mem_input_data = siw_memory_arbiter_reset_n ? data_c : '0;
    end

    assign siw_memory_arbiter_rvalid_0 = rvalid_0_q;
    assign siw_memory_arbiter_rvalid_1 = rvalid_1_q;
    assign siw_memory_arbiter_rdata    = siw_memory_arbiter_mem_output_data;
    assign siw_memory_arbiter_busy     = (state_q == ST_WR_HOLD);
    assign siw_memory_arbiter_mem_conf = DELAY;
    assign siw_memory_arbiter_mem_init = siw_memory_arbiter_init;

endmodule

// File: tb/tb_siw_memory_arbiter.sv
// Bench for siw_memory_arbiter: three instances (WR_DELAY 0, 3, 2), each with
// a behavioural dual-delay RAM port model; read results go through a scoreboard.
module tb_siw_memory_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          init;
    logic          req_0, req_1, we_0, we_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [DW-1:0] wdata_0, wdata_1;

    logic          gnt0  [ND];
    logic          gnt1  [ND];
    logic          rv0   [ND];
    logic          rv1   [ND];
    logic          busy  [ND];
    logic          men   [ND];
    logic          mwe   [ND];
    logic          minit [ND];
    logic [1:0]    mconf [ND];
    logic [AW-1:0] maddr [ND];
    logic [DW-1:0] mdata [ND];
    logic [DW-1:0] rdata [ND];
    logic [DW-1:0] modata[ND];

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   sel   = 0;
    int   wd_tab [ND] = '{0, 3, 2};

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int unsigned WD = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
        logic [DW-1:0] ram [1024];
        logic [DW-1:0] st1;
        logic [1:0]    pend = 2'd0;

        siw_memory_arbiter #(.AW(AW), .DW(DW), .WR_DELAY(WD)) u_dut (
            .siw_memory_arbiter_clk            (clk),
            .siw_memory_arbiter_reset_n        (reset_n),
            .siw_memory_arbiter_init           (init),
            .siw_memory_arbiter_req_0          (req_0),
            .siw_memory_arbiter_req_1          (req_1),
            .siw_memory_arbiter_we_0           (we_0),
            .siw_memory_arbiter_we_1           (we_1),
            .siw_memory_arbiter_addr_0         (addr_0),
            .siw_memory_arbiter_addr_1         (addr_1),
            .siw_memory_arbiter_wdata_0        (wdata_0),
            .siw_memory_arbiter_wdata_1        (wdata_1),
            .siw_memory_arbiter_gnt_0          (gnt0[g]),
            .siw_memory_arbiter_gnt_1          (gnt1[g]),
            .siw_memory_arbiter_rvalid_0       (rv0[g]),
            .siw_memory_arbiter_rvalid_1       (rv1[g]),
            .siw_memory_arbiter_rdata          (rdata[g]),
            .siw_memory_arbiter_busy           (busy[g]),
            .siw_memory_arbiter_mem_enable     (men[g]),
            .siw_memory_arbiter_mem_write_en   (mwe[g]),
            .siw_memory_arbiter_mem_address    (maddr[g]),
            .siw_memory_arbiter_mem_input_data (mdata[g]),
            .siw_memory_arbiter_mem_conf       (mconf[g]),
            .siw_memory_arbiter_mem_init       (minit[g]),
            .siw_memory_arbiter_mem_output_data(modata[g])
        );

        // RAM port model: 2-cycle registered read, write strobe delayed by mem_conf.
        always @(posedge clk) begin
            if (men[g] && !mwe[g]) st1 <= ram[maddr[g]];
            modata[g] <= st1;
            if (minit[g]) begin
                pend <= 2'd0;
            end else if (pend != 2'd0) begin
                if (pend == 2'd1) ram[maddr[g]] <= mdata[g];
                pend <= pend - 2'd1;
            end
            if (men[g] && mwe[g] && !minit[g]) begin
                if (mconf[g] == 2'd0) ram[maddr[g]] <= mdata[g];
                else pend <= mconf[g];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (dut %0d, cycle %0d)", name, act, exp, sel, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every rvalid on the selected instance must match the queue head.
    always @(negedge clk) begin
        if (rv0[sel] || rv1[sel]) begin
            if (rv0[sel] && rv1[sel]) begin
                n_cmp++;
                n_err++;
                $display("FAIL rvalid_onehot: both rvalid high (dut %0d, cycle %0d)", sel, cyc);
            end else if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rvalid_unexpected: rv0=%0b rv1=%0b rdata=0x%0h (dut %0d, cycle %0d)",
                         rv0[sel], rv1[sel], rdata[sel], sel, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("rd_id", 64'(rv1[sel]), 64'(mon_e.id));
                chk("rd_data", 64'(rdata[sel]), 64'(mon_e.data));
                chk("rd_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    // Drive one request (called just after a rising edge), wait for its grant, then drop it.
    task automatic issue(input logic id, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit track, input int exp_wait);
        int   n = 0;
        logic g;
        if (id) begin req_1 = 1'b1; we_1 = we; addr_1 = a; wdata_1 = d; end
        else    begin req_0 = 1'b1; we_0 = we; addr_0 = a; wdata_0 = d; end
        @(negedge clk);
        g = id ? gnt1[sel] : gnt0[sel];
        while (!g && n < 20) begin
            @(negedge clk);
            n++;
            g = id ? gnt1[sel] : gnt0[sel];
        end
        chk("issue_gnt", 64'(g), 64'(1));
        chk("issue_wait", 64'(n), 64'(exp_wait));
        if (g) begin
            chk("issue_mem_en", 64'(men[sel]), 64'(1));
            chk("issue_mem_we", 64'(mwe[sel]), 64'(we));
            chk("issue_mem_addr", 64'(maddr[sel]), 64'(a));
            if (we) chk("issue_mem_wdata", 64'(mdata[sel]), 64'(d));
            if (!we && track) sb.push_back('{id, d, cyc + 2});
        end
        step();
        if (id) req_1 = 1'b0;
        else    req_0 = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        init = 1'b0;
        req_0 = 1'b0;
        req_1 = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; init = 1'b0;
        req_0 = 1'b1; req_1 = 1'b0; we_0 = 1'b0; we_1 = 1'b0;
        addr_0 = 10'h005; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;

        // Reset state, with a request pending that must not be granted.
        @(negedge clk);
        for (int g = 0; g < int'(ND); g++) begin
            sel = g;
            chk("rst_gnt0", 64'(gnt0[g]), 64'(0));
            chk("rst_rvalid", 64'({rv0[g], rv1[g]}), 64'(0));
            chk("rst_busy", 64'(busy[g]), 64'(0));
            chk("rst_mem_en", 64'({men[g], mwe[g]}), 64'(0));
            chk("rst_mem_addr", 64'(maddr[g]), 64'(0));
            chk("rst_mem_wdata", 64'(mdata[g]), 64'(0));
            chk("mem_conf", 64'(mconf[g]), 64'(wd_tab[g]));
        end
        sel = 0;
        req_0 = 1'b0;
        step();
        reset_n = 1'b1;

        // WR_DELAY=0: write then read back on consecutive cycles.
        issue(1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 1'b0, 0);
        issue(1'b0, 1'b0, 10'h005, 32'hDEADBEEF, 1'b1, 0);
        issue(1'b0, 1'b1, 10'h010, 32'hA5A50010, 1'b0, 0);
        issue(1'b1, 1'b1, 10'h020, 32'h5A5A0020, 1'b0, 0);

        // init pulse resets the pointer so requester 0 wins the next conflict.
        init = 1'b1;
        @(negedge clk);
        chk("init_mem_init", 64'(minit[sel]), 64'(1));
        step();
        init = 1'b0;

        // Continuous reads from both requesters alternate 0,1,0,1.
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 10'h010;
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 10'h020;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_gnt0", 64'(gnt0[sel]), 64'((k % 2) == 0));
            chk("rr_gnt1", 64'(gnt1[sel]), 64'((k % 2) == 1));
            if ((k % 2) == 0) sb.push_back('{1'b0, 32'hA5A50010, cyc + 2});
            else              sb.push_back('{1'b1, 32'h5A5A0020, cyc + 2});
            step();
        end
        req_0 = 1'b0; req_1 = 1'b0;
        repeat (4) step();

        // WR_DELAY=3: write to 0x3FF blocks a competing read for three cycles.
        sel = 1;
        do_reset();
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 10'h3FF; wdata_0 = 32'h12345678;
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 10'h3FF;
        @(negedge clk);
        chk("wd3_gnt0", 64'(gnt0[sel]), 64'(1));
        chk("wd3_gnt1", 64'(gnt1[sel]), 64'(0));
        chk("wd3_mem_we", 64'(mwe[sel]), 64'(1));
        chk("wd3_mem_addr", 64'(maddr[sel]), 64'(10'h3FF));
        chk("wd3_mem_wdata", 64'(mdata[sel]), 64'(32'h12345678));
        step();
        req_0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_gnt1", 64'(gnt1[sel]), 64'(0));
            chk("hold_busy", 64'(busy[sel]), 64'(1));
            chk("hold_mem_en", 64'({men[sel], mwe[sel]}), 64'(2'b10));
            chk("hold_mem_addr", 64'(maddr[sel]), 64'(10'h3FF));
            step();
        end
        @(negedge clk);
        chk("wd3_read_gnt1", 64'(gnt1[sel]), 64'(1));
        chk("wd3_read_busy", 64'(busy[sel]), 64'(0));
        if (gnt1[sel]) sb.push_back('{1'b1, 32'h12345678, cyc + 2});
        step();
        req_1 = 1'b0;
        repeat (4) step();

        // WR_DELAY=2: init one cycle after a write grant aborts the write.
        sel = 2;
        do_reset();
        issue(1'b0, 1'b1, 10'h044, 32'h0BAD0BAD, 1'b0, 0);
        issue(1'b0, 1'b1, 10'h044, 32'hFFFF0000, 1'b0, 2);
        init = 1'b1;
        @(negedge clk);
        chk("abort_mem_init", 64'(minit[sel]), 64'(1));
        chk("abort_mem_en", 64'(men[sel]), 64'(0));
        step();
        init = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy[sel]), 64'(0));
        step();
        // Read issued, then init on the following cycle: its result must be dropped.
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 10'h044;
        @(negedge clk);
        chk("drop_gnt1", 64'(gnt1[sel]), 64'(1));
        step();
        req_1 = 1'b0;
        init = 1'b1;
        step();
        init = 1'b0;
        @(negedge clk);
        chk("drop_rvalid1", 64'(rv1[sel]), 64'(0));
        step();
        issue(1'b0, 1'b0, 10'h044, 32'h0BAD0BAD, 1'b1, 0);
        repeat (4) step();

        // Async reset with two reads in flight, then requester 0 wins first.
        sel = 0;
        do_reset();
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 10'h010;
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 10'h020;
        @(negedge clk);
        chk("inflt_gnt0", 64'(gnt0[sel]), 64'(1));
        step();
        req_0 = 1'b0;
        @(negedge clk);
        chk("inflt_gnt1", 64'(gnt1[sel]), 64'(1));
        step();
        req_1 = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("arst_rvalid", 64'({rv0[sel], rv1[sel]}), 64'(0));
        @(negedge clk);
        chk("arst_rvalid_hold", 64'({rv0[sel], rv1[sel]}), 64'(0));
        step();
        reset_n = 1'b1;
        req_0 = 1'b1; req_1 = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt0", 64'(gnt0[sel]), 64'(1));
        chk("post_rst_gnt1", 64'(gnt1[sel]), 64'(0));
        if (gnt0[sel]) sb.push_back('{1'b0, 32'hA5A50010, cyc + 2});
        step();
        req_0 = 1'b0;
        @(negedge clk);
        chk("post_rst_gnt1b", 64'(gnt1[sel]), 64'(1));
        if (gnt1[sel]) sb.push_back('{1'b1, 32'h5A5A0020, cyc + 2});
        step();
        req_1 = 1'b0;
        repeat (5) step();

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
